vga_scan_gen: RTL

- Raster timing generator for the SubAdventure display path: produces the hcount/vcount/blank scan interface consumed by every draw module (waves, sub, enemies), plus hsync/vsync for the VGA connector.
- 640x480 @ 60 Hz timing; pixel rate derived from the system clock by an internal clock-enable divider.
- Also provides a once-per-frame tick that game-logic blocks use to step object positions, e.g. advancing wave X by its nextWave value.

---
 rtl/vga_scan_gen.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/vga_scan_gen.sv
// -----------------------------------------------------------------------------
// vga_scan_gen
//   Raster timing generator for the SubAdventure display path. Produces the
//   hcount/vcount/blank scan interface consumed by the draw modules, hsync and
//   vsync for the VGA connector, a pixel-rate strobe and a once-per-frame tick.
//   Default timing is 640x480 @ 60 Hz with a 25 MHz pixel rate from 50 MHz clk.
//
// Ports
//   clk          in   system clock
//   rst          in   synchronous reset, active-high
//   hcount       out  signed [10:0] current pixel column, 0..H_TOTAL-1
//   vcount       out  signed [10:0] current line, 0..V_TOTAL-1
//   blank        out  high outside the visible region
//   hsync        out  horizontal sync, active-low
//   vsync        out  vertical sync, active-low
//   pix_tick     out  one-clk pulse on the clk at whose end the counters advance
//   frame_tick   out  one-clk pulse on the clk the counters first read (0,0)
//   frame_count  out  [15:0] frames since reset, wraps (VGA_FRAME_COUNT_EN only)
//
// Optional feature macro: VGA_FRAME_COUNT_EN adds the frame_count output.
// -----------------------------------------------------------------------------
module vga_scan_gen #(
  parameter int CLK_DIV   = 2,
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33
) (
  input  logic               clk,
  input  logic               rst,
  output logic signed [10:0] hcount,
  output logic signed [10:0] vcount,
  output logic               blank,
  output logic               hsync,
  output logic               vsync,
  output logic               pix_tick,
  output logic               frame_tick
`ifdef VGA_FRAME_COUNT_EN
  ,
  output logic [15:0]        frame_count
`endif
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
  localparam logic [10:0] V_VIS    = 11'(V_VISIBLE);
  localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [10:0] VS_START = 11'(V_VISIBLE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_VISIBLE + V_FP + V_SYNC);

  logic [DIV_W-1:0] div_q, div_d;
  logic [10:0]      h_q, h_d;
  logic [10:0]      v_q, v_d;
  logic             pix_q;
  logic             blank_q, blank_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             frame_q, frame_d;

  // Next-state: divider phase, raster position and the decodes of the *next*
  // position, so every registered decode lines up with the counts it describes.
  always_comb begin
    div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);

    h_d = h_q;
    v_d = v_q;
    // pix_q is high during the last divider phase; the counters step at its end.
    if (pix_q) begin
      if (h_q == H_LAST) begin
        h_d = 11'd0;
        if (v_q == V_LAST) begin
          v_d = 11'd0;
        end else begin
          v_d = v_q + 11'd1;
        end
      end else begin
        h_d = h_q + 11'd1;
      end
    end else begin
      h_d = h_q;
    end

    blank_d = (h_d >= H_VIS) | (v_d >= V_VIS);
    hsync_d = ~((h_d >= HS_START) & (h_d < HS_END));
    vsync_d = ~((v_d >= VS_START) & (v_d < VS_END));
    // Only a real advance onto (0,0) counts, never the post-reset (0,0).
    frame_d = pix_q & (h_d == 11'd0) & (v_d == 11'd0);
  end

  // State and registered outputs; reset wins over divider phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q   <= '0;
      pix_q   <= 1'b0;
      h_q     <= 11'd0;
      v_q     <= 11'd0;
      blank_q <= 1'b0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      frame_q <= 1'b0;
    end else begin
      div_q   <= div_d;
      pix_q   <= (div_d == DIV_LAST);
      h_q     <= h_d;
      v_q     <= v_d;
      blank_q <= blank_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      frame_q <= frame_d;
    end
  end

`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] fcount_q;

  // Frame counter for animation phase; natural 16-bit wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      fcount_q <= 16'd0;
    end else if (frame_d) begin
      fcount_q <= fcount_q + 16'd1;
    end else begin
      fcount_q <= fcount_q;
    end
  end

  assign frame_count = fcount_q;
`endif

  assign hcount     = $signed(h_q);
  assign vcount     = $signed(v_q);
  assign blank      = blank_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign pix_tick   = pix_q;
  assign frame_tick = frame_q;

endmodule
